jtag_tap_ctrl: RTL and testbench
================================

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 SHALL have parameter IDCODE_VAL, default 32'h1000_0093, meaning the 32-bit value captured by the IDCODE register (bit 0 fixed 1).
REQ-002 SHALL have parameter IR_LEN, default 4, meaning the instruction register width.
REQ-003 SHALL have port tclk  input  1  JTAG test clock; all state on posedge except where noted.
REQ-004 SHALL have port test_logic_reset_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports tms_i  input  1  mode select; tdi_i  input  1  serial data in.
REQ-006 SHALL have ports tdo_o  output  1  serial data out; tdo_oe_o  output  1  TDO drive enable.
REQ-007 SHALL have port chain_tdi_o  output  1  tdi_i forwarded combinationally to all user data chains.
REQ-008 SHALL have ports bs_chain_tdo_i, debug_tdo_i, mbist_tdo_i  input  1 each  serial returns of the boundary-scan, debug and MBIST chains.
REQ-009 SHALL have ports capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o  output  1 each  high while the FSM is in the corresponding state.
REQ-010 SHALL have port tlr_o  output  1  high while the FSM is in TEST_LOGIC_RESET.
REQ-011 SHALL have ports extest_sel_o, sample_preload_sel_o, debug_sel_o, mbist_sel_o  output  1 each  one-hot decode of the latched instruction.

Function
REQ-012 SHALL implement the 16-state IEEE 1149.1 TAP FSM (TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT/CAPTURE/SHIFT/EXIT1/PAUSE/EXIT2/UPDATE for DR and IR), advancing on posedge tclk per tms_i.
REQ-013 SHALL reach TEST_LOGIC_RESET after five consecutive tms_i=1 edges from any state.
REQ-014 SHALL decode the state outputs (REQ-009, REQ-010) combinationally from the current state register; zero added latency.
REQ-015 SHALL load IR shift register with {IR_LEN-2 zeros, 2'b01} in CAPTURE_IR, shift LSB-first with tdi_i entering the MSB in SHIFT_IR, and hold it in all other states.
REQ-016 SHALL copy the IR shift register into the instruction latch on the posedge that leaves UPDATE_IR; the latch SHALL be unchanged in every other state.
REQ-017 SHALL use opcodes EXTEST 4'h0, SAMPLE_PRELOAD 4'h1, IDCODE 4'h2, DEBUG 4'h8, MBIST 4'h9, BYPASS 4'hF; every unlisted opcode SHALL behave as BYPASS.
REQ-018 SHALL assert at most one *_sel_o at any time; IDCODE and BYPASS assert none.
REQ-019 SHALL implement a 1-bit bypass register: loads 0 in CAPTURE_DR, loads tdi_i in SHIFT_DR, when BYPASS is selected.
REQ-020 SHALL implement a 32-bit IDCODE register: loads IDCODE_VAL in CAPTURE_DR, shifts right LSB-first with tdi_i into bit 31 in SHIFT_DR, when IDCODE is selected.
REQ-021 SHALL select the TDO source from the state and instruction: SHIFT_IR->IR shift LSB; SHIFT_DR->bs_chain_tdo_i (EXTEST, SAMPLE_PRELOAD), debug_tdo_i (DEBUG), mbist_tdo_i (MBIST), IDCODE LSB (IDCODE), bypass bit (others).
REQ-022 SHALL register tdo_o and tdo_oe_o on negedge tclk; tdo_oe_o=1 only when the current state is SHIFT_IR or SHIFT_DR, else tdo_o=0.
REQ-023 SHALL latch a new instruction only on the UPDATE_IR exit edge; an IR scan aborted through TEST_LOGIC_RESET SHALL leave the reset instruction latched.

Reset
REQ-024 SHALL, on test_logic_reset_i=1 (asynchronous), force state TEST_LOGIC_RESET, instruction latch IDCODE, IR shift 0, bypass 0, IDCODE register IDCODE_VAL, tdo_o=0, tdo_oe_o=0.
REQ-025 SHALL, while in TEST_LOGIC_RESET via tms_i, reload the instruction latch with the reset instruction on every posedge.
REQ-026 SHALL, after reset, drive tlr_o=1 and all other REQ-009/REQ-011 outputs 0.

Configuration
REQ-027 SHALL honour macro JTAG_TAP_IDCODE_EN: defined -> IDCODE register present, reset instruction IDCODE; undefined -> no IDCODE register, opcode 4'h2 decodes as BYPASS, reset instruction BYPASS.

Structure
REQ-028 SHALL take the TAP state enum, IR_LEN default and opcode constants from shared package jtag_pkg.
REQ-029 SHALL place the 16-state FSM and state decode in sub-module jtag_tap_fsm; IR, data registers and TDO mux stay in jtag_tap_ctrl.

Verification
REQ-030 Reset, then tms 1,1,1,1,1 from SHIFT_DR -> tlr_o=1, no *_sel_o set, IR latch = IDCODE.
REQ-031 Reset, go to SHIFT_DR, shift 32 bits -> tdo_o sequence = 32'h1000_0093 LSB first, tdo_oe_o=1 throughout.
REQ-032 Load IR 4'h1 -> sample_preload_sel_o=1 from the edge after UPDATE_IR; in SHIFT_DR tdo_o follows bs_chain_tdo_i delayed half a cycle.
REQ-033 Load IR 4'h5 (unlisted) -> bypass: shift 1,0,1,1 -> tdo_o = 0,1,0,1 (capture 0 first), no *_sel_o set.
REQ-034 Assert test_logic_reset_i mid-SHIFT_IR of 4'h8 -> debug_sel_o stays 0, tdo_oe_o=0 immediately, IR latch = IDCODE.
REQ-035 Build without JTAG_TAP_IDCODE_EN, reset, shift DR 2 bits of 1 -> tdo_o = 0,1 (bypass), no IDCODE pattern.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, opcodes, instruction classes.
// The IDCODE register is built only when JTAG_TAP_IDCODE_EN is defined.
package jtag_pkg;

  localparam int IR_LEN_DEF = 4;

  localparam logic [3:0] OP_EXTEST         = 4'h0;
  localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'h1;
  localparam logic [3:0] OP_IDCODE         = 4'h2;
  localparam logic [3:0] OP_DEBUG          = 4'h8;
  localparam logic [3:0] OP_MBIST          = 4'h9;
  localparam logic [3:0] OP_BYPASS         = 4'hF;

  typedef enum logic [3:0] {
    ST_TLR    = 4'hF,
    ST_RTI    = 4'hC,
    ST_SEL_DR = 4'h7,
    ST_CAP_DR = 4'h6,
    ST_SH_DR  = 4'h2,
    ST_EX1_DR = 4'h1,
    ST_PA_DR  = 4'h3,
    ST_EX2_DR = 4'h0,
    ST_UPD_DR = 4'h5,
    ST_SEL_IR = 4'h4,
    ST_CAP_IR = 4'hE,
    ST_SH_IR  = 4'hA,
    ST_EX1_IR = 4'h9,
    ST_PA_IR  = 4'hB,
    ST_EX2_IR = 4'h8,
    ST_UPD_IR = 4'hD
  } tap_state_e;

  typedef enum logic [2:0] {
    INS_EXTEST,
    INS_SAMPLE,
    INS_IDCODE,
    INS_DEBUG,
    INS_MBIST,
    INS_BYPASS
  } instr_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller with combinational state decode.
module jtag_tap_fsm import jtag_pkg::*; (
  input  logic tclk,
  input  logic test_logic_reset_i,
  input  logic tms_i,
  output logic tlr,
  output logic capture_dr,
  output logic shift_dr,
  output logic pause_dr,
  output logic update_dr,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir
);

  tap_state_e state, state_nxt;

  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) state <= ST_TLR;
    else                    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_TLR:    state_nxt = tms_i ? ST_TLR    : ST_RTI;
      ST_RTI:    state_nxt = tms_i ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_nxt = tms_i ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_nxt = tms_i ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_nxt = tms_i ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_nxt = tms_i ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  state_nxt = tms_i ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: state_nxt = tms_i ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_nxt = tms_i ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_nxt = tms_i ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_nxt = tms_i ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_nxt = tms_i ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_nxt = tms_i ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  state_nxt = tms_i ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: state_nxt = tms_i ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_nxt = tms_i ? ST_SEL_DR : ST_RTI;
      default:   state_nxt = ST_TLR;
    endcase
  end

  always_comb begin
    tlr        = (state == ST_TLR);
    capture_dr = (state == ST_CAP_DR);
    shift_dr   = (state == ST_SH_DR);
    pause_dr   = (state == ST_PA_DR);
    update_dr  = (state == ST_UPD_DR);
    capture_ir = (state == ST_CAP_IR);
    shift_ir   = (state == ST_SH_IR);
    update_ir  = (state == ST_UPD_IR);
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP: IR, bypass/IDCODE data registers, instruction decode, TDO mux.
// Define JTAG_TAP_IDCODE_EN to build the IDCODE register (reset instruction IDCODE).
module jtag_tap_ctrl import jtag_pkg::*; #(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0093,
  parameter int          IR_LEN     = IR_LEN_DEF
) (
  input  logic tclk,
  input  logic test_logic_reset_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  output logic chain_tdi_o,
  input  logic bs_chain_tdo_i,
  input  logic debug_tdo_i,
  input  logic mbist_tdo_i,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic tlr_o,
  output logic extest_sel_o,
  output logic sample_preload_sel_o,
  output logic debug_sel_o,
  output logic mbist_sel_o
);

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] RST_INSTR = IR_LEN'(OP_IDCODE);
`else
  localparam logic [IR_LEN-1:0] RST_INSTR = {IR_LEN{1'b1}};
`endif

  logic capture_ir, shift_ir, update_ir;
  logic [IR_LEN-1:0] ir_shift, ir_latch;
  logic bypass_reg, id_lsb, tdo_nxt;
  instr_e instr;

  jtag_tap_fsm u_fsm (
    .tclk               (tclk),
    .test_logic_reset_i (test_logic_reset_i),
    .tms_i              (tms_i),
    .tlr                (tlr_o),
    .capture_dr         (capture_dr_o),
    .shift_dr           (shift_dr_o),
    .pause_dr           (pause_dr_o),
    .update_dr          (update_dr_o),
    .capture_ir         (capture_ir),
    .shift_ir           (shift_ir),
    .update_ir          (update_ir)
  );

  assign chain_tdi_o = tdi_i;

  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i)  ir_shift <= '0;
    else if (capture_ir)     ir_shift <= IR_LEN'(2'b01);
    else if (shift_ir)       ir_shift <= {tdi_i, ir_shift[IR_LEN-1:1]};
  end

  // The latch only moves on the UPDATE_IR exit edge, so an aborted scan never lands.
  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i)  ir_latch <= RST_INSTR;
    else if (tlr_o)          ir_latch <= RST_INSTR;
    else if (update_ir)      ir_latch <= ir_shift;
  end

  always_comb begin
    instr = INS_BYPASS;
    if      (ir_latch == IR_LEN'(OP_EXTEST))         instr = INS_EXTEST;
    else if (ir_latch == IR_LEN'(OP_SAMPLE_PRELOAD)) instr = INS_SAMPLE;
    else if (ir_latch == IR_LEN'(OP_DEBUG))          instr = INS_DEBUG;
    else if (ir_latch == IR_LEN'(OP_MBIST))          instr = INS_MBIST;
`ifdef JTAG_TAP_IDCODE_EN
    else if (ir_latch == IR_LEN'(OP_IDCODE))         instr = INS_IDCODE;
`endif
  end

  assign extest_sel_o         = (instr == INS_EXTEST);
  assign sample_preload_sel_o = (instr == INS_SAMPLE);
  assign debug_sel_o          = (instr == INS_DEBUG);
  assign mbist_sel_o          = (instr == INS_MBIST);

  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) bypass_reg <= 1'b0;
    else if (instr == INS_BYPASS) begin
      if (capture_dr_o)     bypass_reg <= 1'b0;
      else if (shift_dr_o)  bypass_reg <= tdi_i;
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_reg;

  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) idcode_reg <= IDCODE_VAL;
    else if (instr == INS_IDCODE) begin
      if (capture_dr_o)     idcode_reg <= IDCODE_VAL;
      else if (shift_dr_o)  idcode_reg <= {tdi_i, idcode_reg[31:1]};
    end
  end

  assign id_lsb = idcode_reg[0];
`else
  assign id_lsb = 1'b0;
`endif

  always_comb begin
    tdo_nxt = 1'b0;
    if (shift_ir) tdo_nxt = ir_shift[0];
    else if (shift_dr_o) begin
      unique case (instr)
        INS_EXTEST, INS_SAMPLE: tdo_nxt = bs_chain_tdo_i;
        INS_DEBUG:              tdo_nxt = debug_tdo_i;
        INS_MBIST:              tdo_nxt = mbist_tdo_i;
        INS_IDCODE:             tdo_nxt = id_lsb;
        default:                tdo_nxt = bypass_reg;
      endcase
    end
  end

  // Falling-edge launch gives the receiver a half cycle of setup before the next rising edge.
  always_ff @(negedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_o    <= tdo_nxt;
      tdo_oe_o <= shift_ir | shift_dr_o;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed + random bench for jtag_tap_ctrl against a table-driven TAP reference model.
module tb_jtag_tap_ctrl;
  localparam logic [31:0] IDV = 32'h1000_0093;
  localparam int IRL = 4;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam logic [IRL-1:0] RST_OP = ID_EN ? 4'h2 : 4'hF;

  localparam int S_TLR = 0, S_RTI = 1, S_SDS = 2, S_CDR = 3, S_SDR = 4, S_E1D = 5,
                 S_PDR = 6, S_E2D = 7, S_UDR = 8, S_SIS = 9, S_CIR = 10, S_SIR = 11,
                 S_E1I = 12, S_PIR = 13, S_E2I = 14, S_UIR = 15;
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic tclk = 1'b0, rst = 1'b0, tms = 1'b1, tdi = 1'b0, bs = 1'b0, dbg = 1'b0, mb = 1'b0;
  logic tdo, tdo_oe, chain_tdi, cap_dr, sh_dr, pa_dr, up_dr, tlr;
  logic ext_sel, sp_sel, dbg_sel, mb_sel;

  int total = 0, bad = 0;

  int m_st;
  logic [IRL-1:0] m_irs, m_lat;
  logic m_byp, m_tdo, m_oe;
  logic [31:0] m_id;
  logic [31:0] got;
  int gn;

  jtag_tap_ctrl #(.IDCODE_VAL(IDV), .IR_LEN(IRL)) dut (
    .tclk(tclk), .test_logic_reset_i(rst), .tms_i(tms), .tdi_i(tdi),
    .tdo_o(tdo), .tdo_oe_o(tdo_oe), .chain_tdi_o(chain_tdi),
    .bs_chain_tdo_i(bs), .debug_tdo_i(dbg), .mbist_tdo_i(mb),
    .capture_dr_o(cap_dr), .shift_dr_o(sh_dr), .pause_dr_o(pa_dr), .update_dr_o(up_dr),
    .tlr_o(tlr), .extest_sel_o(ext_sel), .sample_preload_sel_o(sp_sel),
    .debug_sel_o(dbg_sel), .mbist_sel_o(mb_sel)
  );

  always #5 tclk = ~tclk;

  // 0 extest, 1 sample, 2 idcode, 3 debug, 4 mbist, 5 bypass
  function automatic int cls(input logic [IRL-1:0] op);
    case (op)
      4'h0: return 0;
      4'h1: return 1;
      4'h2: return ID_EN ? 2 : 5;
      4'h8: return 3;
      4'h9: return 4;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int c;
    c = cls(m_lat);
    chk("tlr", 32'(tlr), 32'(m_st == S_TLR));
    chk("capture_dr", 32'(cap_dr), 32'(m_st == S_CDR));
    chk("shift_dr", 32'(sh_dr), 32'(m_st == S_SDR));
    chk("pause_dr", 32'(pa_dr), 32'(m_st == S_PDR));
    chk("update_dr", 32'(up_dr), 32'(m_st == S_UDR));
    chk("extest_sel", 32'(ext_sel), 32'(c == 0));
    chk("sample_sel", 32'(sp_sel), 32'(c == 1));
    chk("debug_sel", 32'(dbg_sel), 32'(c == 3));
    chk("mbist_sel", 32'(mb_sel), 32'(c == 4));
    chk("chain_tdi", 32'(chain_tdi), 32'(tdi));
  endtask

  task automatic model_reset();
    m_st = S_TLR; m_lat = RST_OP; m_irs = '0; m_byp = 1'b0; m_id = IDV;
    m_tdo = 1'b0; m_oe = 1'b0;
  endtask

  task automatic model_pos();
    int c;
    c = cls(m_lat);
    if (m_st == S_CIR) m_irs = IRL'(1);
    else if (m_st == S_SIR) m_irs = (m_irs >> 1) | (IRL'(tdi) << (IRL - 1));
    if (m_st == S_UIR) m_lat = m_irs;
    else if (m_st == S_TLR) m_lat = RST_OP;
    if (c == 5 && m_st == S_CDR) m_byp = 1'b0;
    else if (c == 5 && m_st == S_SDR) m_byp = tdi;
    if (c == 2 && m_st == S_CDR) m_id = IDV;
    else if (c == 2 && m_st == S_SDR) m_id = (m_id >> 1) | (32'(tdi) << 31);
    m_st = tms ? nxt1[m_st] : nxt0[m_st];
  endtask

  task automatic model_neg();
    int c;
    c = cls(m_lat);
    m_oe = (m_st == S_SIR) || (m_st == S_SDR);
    m_tdo = 1'b0;
    if (m_st == S_SIR) m_tdo = m_irs[0];
    else if (m_st == S_SDR)
      case (c)
        0, 1: m_tdo = bs;
        2: m_tdo = m_id[0];
        3: m_tdo = dbg;
        4: m_tdo = mb;
        default: m_tdo = m_byp;
      endcase
  endtask

  // Called just after a falling edge; leaves just after the next falling edge.
  task automatic step(input bit t, input bit d);
    tms = t; tdi = d;
    bs = 1'($urandom); dbg = 1'($urandom); mb = 1'($urandom);
    @(posedge tclk);
    model_pos();
    #1 chk_state();
    @(negedge tclk);
    model_neg();
    #1;
    chk("tdo_oe", 32'(tdo_oe), 32'(m_oe));
    chk("tdo", 32'(tdo), 32'(m_tdo));
    if (m_oe && gn < 32) begin got[gn] = tdo; gn++; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_tdo_oe", 32'(tdo_oe), 32'(0));
    chk("rst_tdo", 32'(tdo), 32'(0));
    chk_state();
    #1 rst = 1'b0;
  endtask

  task automatic load_ir(input logic [IRL-1:0] op);
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IRL; i++) step(i == IRL - 1, op[i]);
    step(1, 0); step(0, 0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] data);
    got = '0; gn = 0;
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) step(i == n - 1, data[i]);
    step(1, 0); step(0, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic [IRL-1:0] ops [5] = '{4'h0, 4'h8, 4'h9, 4'h2, 4'hF};
    got = '0; gn = 0;
    model_reset();
    #1 do_reset();
    chk("reset_tlr", 32'(tlr), 32'(1));

    // IDCODE (or bypass) shift straight out of reset
    d = $urandom;
    scan_dr(32, d);
    chk("id_scan", got, ID_EN ? IDV : {d[30:0], 1'b0});

    // five TMS=1 edges from SHIFT_DR
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("tlr5", 32'(tlr), 32'(1));
    chk("tlr5_sel", 32'({ext_sel, sp_sel, dbg_sel, mb_sel}), 32'(0));

    load_ir(4'h1);
    chk("sample_sel_on", 32'(sp_sel), 32'(1));
    scan_dr(8, $urandom);

    load_ir(4'h5);
    scan_dr(4, 32'b1101);
    chk("bypass_seq", got[3:0], 32'b1010);
    chk("bypass_nosel", 32'({ext_sel, sp_sel, dbg_sel, mb_sel}), 32'(0));

    // reset aborts an IR scan of DEBUG
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); step(0, 0);
    do_reset();
    chk("abort_dbg_sel", 32'(dbg_sel), 32'(0));
    scan_dr(32, 32'h0);
    chk("abort_latch", got, ID_EN ? IDV : 32'h0);

    do_reset();
    scan_dr(2, 32'b11);
    chk("two_bit", got[1:0], ID_EN ? 32'(IDV[1:0]) : 32'b10);

    for (int k = 0; k < 5; k++) begin
      load_ir(ops[k]);
      scan_dr(6, $urandom);
    end

    for (int k = 0; k < 500; k++) step(1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
